// File: rtl/output_preprocessor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : output_preprocessor_pkg
// Description : Shared widths, saturation constants, pipeline-stage records
//               and the saturating-narrow helper for output_preprocessor.
// Revision    : 1.0 - initial release
// ============================================================================
package output_preprocessor_pkg;

  localparam int W_CHAN = 16;
  localparam int W_SEL  = 4;
  localparam int N_CHAN = 8;

  // Signed range limits of a W_CHAN-bit channel word.
  localparam logic [W_CHAN-1:0] SAT_MAX = {1'b0, {(W_CHAN-1){1'b1}}};
  localparam logic [W_CHAN-1:0] SAT_MIN = {1'b1, {(W_CHAN-1){1'b0}}};

  // Issue stage: raw sample plus the full parameter snapshot of its channel.
  typedef struct packed {
    logic              valid;
    logic [W_SEL-1:0]  chan;
    logic [W_CHAN-1:0] value;
    logic [W_CHAN-1:0] offset;
    logic [W_CHAN-1:0] min_v;
    logic [W_CHAN-1:0] max_v;
    logic [W_CHAN-1:0] max_delta;
  } issue_stage_t;

  // Clamp stage: offset already applied, so only the limits travel on.
  typedef struct packed {
    logic              valid;
    logic [W_SEL-1:0]  chan;
    logic [W_CHAN-1:0] value;
    logic [W_CHAN-1:0] min_v;
    logic [W_CHAN-1:0] max_v;
    logic [W_CHAN-1:0] max_delta;
  } clamp_stage_t;

  // Narrow a W_CHAN+1 bit signed sum to W_CHAN bits, saturating on overflow.
  function automatic logic [W_CHAN-1:0] sat_narrow(input logic [W_CHAN:0] x);
    if (x[W_CHAN] != x[W_CHAN-1]) begin
      return x[W_CHAN] ? SAT_MIN : SAT_MAX;
    end
    return x[W_CHAN-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/output_preprocessor_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first request at or after the
//               pointer whose mask bit is clear.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N_REQ = 8,
  parameter int W_IDX = 4
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] mask_i,
  input  logic [W_IDX-1:0] ptr_i,
  output logic [W_IDX-1:0] grant_o,
  output logic             grant_valid_o
);

  logic [N_REQ-1:0] elig_w;
  logic [N_REQ-1:0] rot_w;
  logic [W_IDX-1:0] off_w;
  logic [W_IDX:0]   sum_w;

  assign elig_w = req_i & ~mask_i;

  // Rotate eligibility so the pointer sits at bit 0, take the lowest set bit,
  // then rotate the offset back into an absolute channel index.
  always_comb begin
    rot_w         = N_REQ'({elig_w, elig_w} >> ptr_i);
    off_w         = '0;
    grant_valid_o = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_w[k]) begin
        off_w         = W_IDX'(k);
        grant_valid_o = 1'b1;
      end
    end
    sum_w = {1'b0, ptr_i} + {1'b0, off_w};
    if (sum_w >= (W_IDX+1)'(N_REQ)) begin
      sum_w = sum_w - (W_IDX+1)'(N_REQ);
    end
    grant_o = sum_w[W_IDX-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/output_preprocessor.sv
`default_nettype none
// ============================================================================
// Module      : output_preprocessor
// Description : Per-channel offset, saturation, clamp and slew limiting on a
//               single time-multiplexed pipeline fed by a round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module output_preprocessor
  import output_preprocessor_pkg::*;
(
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic [W_CHAN*N_CHAN-1:0] data_packed_in,
  input  logic [N_CHAN-1:0]        data_valid_in,
  input  logic [W_SEL-1:0]         chan_select_in,
  input  logic [W_CHAN-1:0]        offset_in,
  input  logic [W_CHAN-1:0]        min_in,
  input  logic [W_CHAN-1:0]        max_in,
  input  logic [W_CHAN-1:0]        max_delta_in,
  input  logic                     update_in,
  output logic [W_CHAN*N_CHAN-1:0] data_packed_out,
  output logic [N_CHAN-1:0]        data_valid_out
);

  logic [W_CHAN-1:0]  hold_q   [N_CHAN];
  logic [N_CHAN-1:0]  pending_q, pending_d;
  logic [W_SEL-1:0]   rr_ptr_q, rr_ptr_d;

  logic [W_CHAN-1:0]  offset_q [N_CHAN];
  logic [W_CHAN-1:0]  min_q    [N_CHAN];
  logic [W_CHAN-1:0]  max_q    [N_CHAN];
  logic [W_CHAN-1:0]  mdelta_q [N_CHAN];

  issue_stage_t       s1_q, s1_d;
  clamp_stage_t       s2_q, s2_d;

  logic [W_CHAN-1:0]  out_q    [N_CHAN];
  logic [N_CHAN-1:0]  valid_out_q;

  logic [N_CHAN-1:0]  busy_w;
  logic [W_SEL-1:0]   grant_w;
  logic               grant_valid_w;

  logic [W_CHAN-1:0]  clamp_w;
  logic [W_CHAN-1:0]  last_w;
  logic [W_CHAN:0]    diff_w;
  logic [W_CHAN:0]    mag_w;
  logic [W_CHAN-1:0]  slew_w;

  // A channel is busy while it sits in issue, clamp or output stage, which
  // spaces results of one channel at least four cycles apart.
  always_comb begin
    busy_w = valid_out_q;
    for (int i = 0; i < N_CHAN; i++) begin
      if (s1_q.valid && s1_q.chan == W_SEL'(i)) busy_w[i] = 1'b1;
      if (s2_q.valid && s2_q.chan == W_SEL'(i)) busy_w[i] = 1'b1;
    end
  end

  rr_arbiter #(
    .N_REQ (N_CHAN),
    .W_IDX (W_SEL)
  ) u_arb (
    .req_i         (pending_q),
    .mask_i        (busy_w),
    .ptr_i         (rr_ptr_q),
    .grant_o       (grant_w),
    .grant_valid_o (grant_valid_w)
  );

  // Issue clears pending, but a fresh pulse in the same cycle re-arms it.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < N_CHAN; i++) begin
      if (grant_valid_w && grant_w == W_SEL'(i)) pending_d[i] = 1'b0;
      if (data_valid_in[i]) pending_d[i] = 1'b1;
    end
  end

  // Latch incoming samples; a later pulse simply overwrites an unissued one.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      pending_q <= '0;
      for (int i = 0; i < N_CHAN; i++) hold_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      for (int i = 0; i < N_CHAN; i++) begin
        if (data_valid_in[i]) hold_q[i] <= data_packed_in[i*W_CHAN +: W_CHAN];
      end
    end
  end

  // Parameter bank; selects beyond the channel count match no entry.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < N_CHAN; i++) begin
        offset_q[i] <= '0;
        min_q[i]    <= SAT_MIN;
        max_q[i]    <= SAT_MAX;
        mdelta_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CHAN; i++) begin
        if (update_in && chan_select_in == W_SEL'(i)) begin
          offset_q[i] <= offset_in;
          min_q[i]    <= min_in;
          max_q[i]    <= max_in;
          mdelta_q[i] <= max_delta_in;
        end
      end
    end
  end

  // Snapshot the granted channel's sample and parameters; bump the pointer.
  always_comb begin
    s1_d     = '0;
    rr_ptr_d = rr_ptr_q;
    if (grant_valid_w) begin
      for (int i = 0; i < N_CHAN; i++) begin
        if (grant_w == W_SEL'(i)) begin
          s1_d.value     = hold_q[i];
          s1_d.offset    = offset_q[i];
          s1_d.min_v     = min_q[i];
          s1_d.max_v     = max_q[i];
          s1_d.max_delta = mdelta_q[i];
        end
      end
      s1_d.valid = 1'b1;
      s1_d.chan  = grant_w;
      rr_ptr_d   = (grant_w == W_SEL'(N_CHAN - 1)) ? '0 : grant_w + W_SEL'(1);
    end
  end

  // Offset add at one extra bit, then saturate back to channel width.
  always_comb begin
    s2_d           = '0;
    s2_d.valid     = s1_q.valid;
    s2_d.chan      = s1_q.chan;
    s2_d.min_v     = s1_q.min_v;
    s2_d.max_v     = s1_q.max_v;
    s2_d.max_delta = s1_q.max_delta;
    s2_d.value     = sat_narrow({s1_q.value[W_CHAN-1], s1_q.value} +
                                {s1_q.offset[W_CHAN-1], s1_q.offset});
  end

  // Pipeline stage registers and round-robin pointer.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      s1_q     <= '0;
      s2_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Clamp (max first, so min wins when inverted) then slew-limit against the
  // channel's current output word.
  always_comb begin
    clamp_w = ($signed(s2_q.value) > $signed(s2_q.max_v)) ? s2_q.max_v : s2_q.value;
    if ($signed(clamp_w) < $signed(s2_q.min_v)) clamp_w = s2_q.min_v;

    last_w = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (s2_q.chan == W_SEL'(i)) last_w = out_q[i];
    end

    diff_w = {clamp_w[W_CHAN-1], clamp_w} - {last_w[W_CHAN-1], last_w};
    mag_w  = diff_w[W_CHAN] ? (~diff_w + (W_CHAN+1)'(1)) : diff_w;
    slew_w = clamp_w;
    if (s2_q.max_delta != '0 && mag_w > {1'b0, s2_q.max_delta}) begin
      slew_w = diff_w[W_CHAN] ? (last_w - s2_q.max_delta) : (last_w + s2_q.max_delta);
    end
  end

  // Output slots only change together with their one-cycle valid pulse.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      valid_out_q <= '0;
      for (int i = 0; i < N_CHAN; i++) out_q[i] <= '0;
    end else begin
      valid_out_q <= '0;
      for (int i = 0; i < N_CHAN; i++) begin
        if (s2_q.valid && s2_q.chan == W_SEL'(i)) begin
          out_q[i]       <= slew_w;
          valid_out_q[i] <= 1'b1;
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < N_CHAN; g++) begin : g_pack
      assign data_packed_out[g*W_CHAN +: W_CHAN] = out_q[g];
    end
  endgenerate

  assign data_valid_out = valid_out_q;

endmodule
`default_nettype wire

// File: doc/output_preprocessor.md
# output_preprocessor

Per-channel conditioning stage directly downstream of the channel router. It takes the router's packed output channels and applies, per channel, a signed offset, min/max saturation, and a slew-rate limit. Results go to the DAC/output interface as a packed bus with per-channel valid pulses. One shared three-stage datapath is time-multiplexed across channels by a round-robin arbiter.

## Interface

- W_CHAN, 16: channel data width, signed two's complement.
- W_SEL, 4: channel select width.
- N_CHAN, 8: number of channels; must be ≤ 2^W_SEL.
- clk_in  input  1  system clock, rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- data_packed_in  input  W_CHAN*N_CHAN  router output; channel i at [i*W_CHAN +: W_CHAN].
- data_valid_in  input  N_CHAN  one-cycle pulse per channel; new sample present.
- chan_select_in  input  W_SEL  channel whose parameters are written.
- offset_in  input  W_CHAN  signed offset.
- min_in  input  W_CHAN  signed lower limit.
- max_in  input  W_CHAN  signed upper limit.
- max_delta_in  input  W_CHAN  unsigned maximum step per output; 0 disables limiting.
- update_in  input  1  one-cycle pulse, synchronous to clk_in; writes all four parameters for chan_select_in.
- data_packed_out  output  W_CHAN*N_CHAN  conditioned channels, held between updates.
- data_valid_out  output  N_CHAN  one-cycle pulse when a channel's output changes register.

## Operation

- Capture: on data_valid_in[i], latch the channel slice into hold[i] and set pending[i].
  - If a new sample arrives while pending[i] is set, it overwrites the held sample; only one result is produced.
- Arbiter: each cycle, issue the first pending channel at or after rr_ptr that is not already in the pipeline (S1–S3).
  - On issue, clear pending[i], advance rr_ptr to i+1 mod N_CHAN, and snapshot hold[i] and channel i's parameters into S1.
  - If the same channel pulses data_valid_in in its issue cycle, the set wins and pending stays 1.
  - If nothing is eligible, insert a bubble.
- S1: sum = sample + offset, computed at W_CHAN+1 bits; saturate to the signed W_CHAN range.
- S2: clamp. If sum > max, use max. Then if result < min, use min. When min > max, min wins.
- S3: slew limit against last[i], the current output register.
  - If max_delta ≠ 0 and |v − last[i]| > max_delta, the result is last[i] ± max_delta, moving toward v.
  - The difference is computed at W_CHAN+1 bits.
  - Write the result to output slot i and pulse data_valid_out[i].
- Parameter writes take effect for samples issued after the update_in cycle. In-flight samples keep their snapshot.
- update_in with chan_select_in ≥ N_CHAN is ignored.
- Reset values, applied on reset_in (mid-pipeline work is discarded):
  - data_packed_out = 0, data_valid_out = 0.
  - pending, hold and pipeline valids = 0; rr_ptr = 0.
  - Per channel: offset = 0, min = most negative, max = most positive, max_delta = 0.

## Timing

- Uncontended latency: data_valid_in in cycle 0 → data_valid_out and updated data in cycle 4.
  - Cycle 0: capture.
  - Cycle 1: issue.
  - Cycles 2–3: S1, S2.
  - Cycle 4: output register.
- Throughput is one channel per cycle. With N_CHAN simultaneous pulses, the last result appears at cycle 4 + N_CHAN − 1.
- A single channel can produce at most one result every 4 cycles, because of the in-flight exclusion.
- data_packed_out changes only in the cycle its data_valid_out bit pulses.

## Structure

- Package output_preprocessor_pkg holds:
  - saturation helper constants (signed max/min of W_CHAN);
  - the pipeline-stage record typedef (channel index, value, parameter snapshot, valid).
- Sub-module rr_arbiter (N_CHAN request vector, mask, pointer → grant index plus grant valid) is the natural split.

## Test plan

- Reset defaults: channel 2 sample 0x1234 → data_valid_out[2] in cycle 4, output 0x1234.
- Offset saturation: offset 0x7000 on channel 0, sample 0x2000 → 0x7FFF.
- Clamp: max = 100, min = −100; sample 500 → 100; sample −500 → −100. With min = 50 and max = 10 → 50.
- Slew: max_delta = 10, last = 0; samples 100, 100, 100 four cycles apart → 10, 20, 30. With max_delta = 0 → 100.
- Contention: all 8 valids pulse together with rr_ptr = 3 → results ordered 3,4,5,6,7,0,1,2 in cycles 4–11. A re-pulse of channel 3 in cycle 1 yields a second channel-3 result after the in-flight window.
- Reset asserted with 3 samples in flight → no data_valid_out afterwards, outputs 0.
